fir_fft_framer: RTL and testbench
=================================

// Module: fir_fft_framer
// PURPOSE
//  Sink-side consumer of the FIR filter's Avalon-ST source (37-bit data + valid, no ready).
//  Rounds/saturates each filtered sample to OUT_W bits and buffers it in an internal FIFO.
//  Emits fixed-length packets (sop/eop, ready backpressure) toward the FFT's Avalon-ST sink.
//  Sits between the FIR filter and the FFT in the DDS->FIR->FFT chain.
// PARAMETERS
//  IN_W       37    width of FIR output sample (signed, two's complement)
//  OUT_W      16    width of framed output sample (signed)
//  SHIFT      12    right-shift applied before saturation; must be >= 1
//  FRAME_LEN  256   samples per packet; power of two, >= 4
//  DEPTH      512   FIFO depth in samples; power of two, >= 2*FRAME_LEN
// PORTS
//  clk        in   1      system clock
//  rst_n      in   1      synchronous reset, active-low
//  fir_data   in   IN_W   filtered sample from FIR source
//  fir_valid  in   1      fir_data valid this cycle (no backpressure possible)
//  src_data   out  OUT_W  framed sample to FFT sink
//  src_valid  out  1      src_data valid
//  src_sop    out  1      first beat of packet
//  src_eop    out  1      last beat of packet
//  src_ready  in   1      FFT sink accepts beat when src_valid & src_ready
//  ovf        out  1      sticky: at least one sample dropped (FIFO full)
//  sat        out  1      sticky: at least one sample saturated
// BEHAVIOUR
//  Reset: rst_n sampled on rising clk only.
//   - Reset values: src_valid=0, src_sop=0, src_eop=0, src_data=0, ovf=0, sat=0.
//   - FIFO emptied, beat counter=0, state=IDLE.
//   - Reset mid-packet aborts the packet; no eop is issued.
//  Scaling stage (1 register, latency 1 from fir_valid to FIFO write):
//   - r = (fir_data + 2^(SHIFT-1)) >>> SHIFT: arithmetic, round-half-up, computed at IN_W+1 bits.
//   - r > 2^(OUT_W-1)-1 -> clamp to 2^(OUT_W-1)-1, set sat.
//   - r < -2^(OUT_W-1) -> clamp to -2^(OUT_W-1), set sat.
//   - Scaled sample is written to the FIFO one cycle after fir_valid=1.
//  FIFO:
//   - Write when full: sample dropped, ovf set, FIFO contents unchanged.
//   - Simultaneous read and write when full: the write succeeds, because the read frees a slot in the same cycle.
//   - Occupancy counter cnt: increments on write-only, decrements on read-only, unchanged on both.
//  FSM:
//   - IDLE -> SEND when cnt >= FRAME_LEN. Checked every cycle, including the cycle after eop is accepted.
//   - SEND: src_valid=1 every cycle until FRAME_LEN beats are accepted; data comes from the FIFO head.
//   - SEND -> IDLE when the beat with eop is accepted. Back-to-back packets are allowed (IDLE lasts 1 cycle).
//   - A packet is entered only with a full frame buffered, so src_valid never drops mid-packet.
//  Output rules:
//   - src_data/sop/eop are registered and held stable while src_valid & !src_ready.
//   - src_sop=1 only on beat 0; src_eop=1 only on beat FRAME_LEN-1.
//   - Sample order is preserved. Dropped samples are simply absent; no realignment is done.
//  Throughput: with src_ready held 1, one beat per cycle in SEND.
// TESTING
//  T1: SHIFT=12, fir_data=0x0000001800 (6144) -> FIFO sample 2 (6144/4096=1.5, rounds up); 0x0000000800 -> 1; 0x1FFFFFF800 (-2048) -> 0.
//  T2: fir_data = +2^30 and -2^30 -> samples 32767 and -32768 respectively; sat=1; ovf stays 0.
//  T3: ramp 0..255 (pre-shifted by 4096), fir_valid=1, src_ready=1 -> one packet 0..255.
//      sop on beat 0, eop on beat 255, src_valid continuous for 256 cycles.
//  T4: src_ready toggles 1,0,1,0 during a packet -> each beat held until accepted.
//      Exactly 256 beats, no duplicates or gaps in the ramp.
//  T5: src_ready=0 while 600 samples arrive -> FIFO holds the first 512, ovf=1.
//      After src_ready=1: two packets of 256 with values 0..511.
//  T6: rst_n=0 for one cycle at beat 100 of a packet -> next cycle src_valid=0, ovf=0, sat=0.
//      A new packet starts only after 256 fresh samples; its first value is the first post-reset sample.

Source files
------------

// File: rtl/fir_fft_framer.sv
// -----------------------------------------------------------------------------
// fir_fft_framer
// Takes the FIR filter's Avalon-ST output and turns it into fixed-length
// packets for the FFT's Avalon-ST sink. The FIR source has no ready signal.
//
// Processing steps:
//   1. Scaling register: round-half-up arithmetic right shift by SHIFT,
//      then saturate to OUT_W bits. The sticky flag 'sat' records clamping.
//   2. FIFO of DEPTH samples. A write into a full FIFO is dropped and the
//      sticky flag 'ovf' is set. A write in the same cycle as a read always
//      succeeds.
//   3. Packet FSM: a packet starts only when a whole frame is buffered, so
//      src_valid stays high for all FRAME_LEN beats of a packet.
//
// Ports:
//   clk        system clock
//   rst_n      synchronous reset, active-low
//   fir_data   filtered sample (IN_W bits, signed)
//   fir_valid  fir_data valid this cycle
//   src_data   framed sample (OUT_W bits, signed)
//   src_valid  src_data valid
//   src_sop    first beat of a packet
//   src_eop    last beat of a packet
//   src_ready  sink accepts a beat when src_valid & src_ready
//   ovf        sticky: at least one sample was dropped
//   sat        sticky: at least one sample was saturated
// -----------------------------------------------------------------------------
module fir_fft_framer #(
    parameter int IN_W      = 37,
    parameter int OUT_W     = 16,
    parameter int SHIFT     = 12,
    parameter int FRAME_LEN = 256,
    parameter int DEPTH     = 512
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  fir_data,
    input  logic             fir_valid,
    output logic [OUT_W-1:0] src_data,
    output logic             src_valid,
    output logic             src_sop,
    output logic             src_eop,
    input  logic             src_ready,
    output logic             ovf,
    output logic             sat
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(FRAME_LEN);

    localparam logic        [IN_W:0]  RND_C   = (IN_W+1)'(1) << (SHIFT-1);
    localparam logic signed [IN_W:0]  MAX_C   = (IN_W+1)'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
    localparam logic signed [IN_W:0]  MIN_C   = ~MAX_C;
    localparam logic        [AW:0]    FRAME_C = (AW+1)'(FRAME_LEN);
    localparam logic        [AW:0]    DEPTH_C = (AW+1)'(DEPTH);
    localparam logic        [BW-1:0]  LAST_C  = BW'(FRAME_LEN-1);
    localparam logic        [BW-1:0]  PEN_C   = BW'(FRAME_LEN-2);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Rounds and saturates one sample. Bit OUT_W of the result is the
    // saturation flag, and the low OUT_W bits are the sample. The arithmetic is
    // done one bit wider than the input so that adding the rounding constant
    // cannot overflow.
    function automatic logic [OUT_W:0] scale_sample(input logic [IN_W-1:0] d);
        logic signed [IN_W:0] sum_v;
        logic signed [IN_W:0] shr_v;
        logic        [OUT_W:0] res_v;
        sum_v = $signed({d[IN_W-1], d}) + $signed(RND_C);
        shr_v = sum_v >>> SHIFT;
        if (shr_v > MAX_C) begin
            res_v = {1'b1, MAX_C[OUT_W-1:0]};
        end else if (shr_v < MIN_C) begin
            res_v = {1'b1, MIN_C[OUT_W-1:0]};
        end else begin
            res_v = {1'b0, shr_v[OUT_W-1:0]};
        end
        return res_v;
    endfunction

    logic [OUT_W:0]   scaled_s;
    logic [OUT_W-1:0] scl_data_r;
    logic             scl_vld_r;

    logic [OUT_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    rd_nx_s;
    logic [AW:0]      cnt_r;
    logic             rd_en_s;
    logic             full_s;
    logic             wr_ok_s;
    logic             drop_s;

    state_t           state_r;
    state_t           state_nx_s;
    logic [BW-1:0]    beat_r;
    logic             start_s;
    logic             adv_s;
    logic             done_s;

    // Rounding and saturation of the incoming sample
    always_comb begin
        scaled_s = scale_sample(fir_data);
    end

    // Scaling register; sets the sticky saturation flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_vld_r  <= 1'b0;
            scl_data_r <= '0;
            sat        <= 1'b0;
        end else begin
            scl_vld_r <= fir_valid;
            if (fir_valid) begin
                scl_data_r <= scaled_s[OUT_W-1:0];
                if (scaled_s[OUT_W]) begin
                    sat <= 1'b1;
                end
            end
        end
    end

    // FIFO control. A beat being accepted this cycle frees a slot, so a
    // write in that cycle succeeds even when the FIFO is full.
    always_comb begin
        rd_en_s = src_valid & src_ready;
        full_s  = (cnt_r == DEPTH_C);
        wr_ok_s = scl_vld_r & (~full_s | rd_en_s);
        drop_s  = scl_vld_r & full_s & ~rd_en_s;
        rd_nx_s = rd_ptr_r + AW'(1);
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (rst_n && wr_ok_s) begin
            mem_r[wr_ptr_r] <= scl_data_r;
        end
    end

    // FIFO pointers, occupancy count and sticky overflow flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
            ovf      <= 1'b0;
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_nx_s;
            end
            case ({wr_ok_s, rd_en_s})
                2'b10:   cnt_r <= cnt_r + (AW+1)'(1);
                2'b01:   cnt_r <= cnt_r - (AW+1)'(1);
                default: cnt_r <= cnt_r;
            endcase
            if (drop_s) begin
                ovf <= 1'b1;
            end
        end
    end

    // Packet FSM: next state and the load/advance/finish strobes
    always_comb begin
        state_nx_s = state_r;
        start_s    = 1'b0;
        adv_s      = 1'b0;
        done_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cnt_r >= FRAME_C) begin
                    state_nx_s = ST_SEND;
                    start_s    = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (rd_en_s) begin
                    if (beat_r == LAST_C) begin
                        state_nx_s = ST_IDLE;
                        done_s     = 1'b1;
                    end else begin
                        adv_s = 1'b1;
                    end
                end else begin
                    state_nx_s = ST_SEND;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Output beat register. It is loaded from the FIFO head on packet entry.
    // After each accepted beat it is loaded from the entry behind the head,
    // which is already present because the whole frame was buffered before
    // the packet started.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            src_valid <= 1'b0;
            src_sop   <= 1'b0;
            src_eop   <= 1'b0;
            src_data  <= '0;
            beat_r    <= '0;
        end else if (start_s) begin
            src_valid <= 1'b1;
            src_sop   <= 1'b1;
            src_eop   <= 1'b0;
            src_data  <= mem_r[rd_ptr_r];
            beat_r    <= '0;
        end else if (adv_s) begin
            src_sop   <= 1'b0;
            src_eop   <= (beat_r == PEN_C);
            src_data  <= mem_r[rd_nx_s];
            beat_r    <= beat_r + BW'(1);
        end else if (done_s) begin
            src_valid <= 1'b0;
            src_sop   <= 1'b0;
            src_eop   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_fft_framer.sv
// -----------------------------------------------------------------------------
// tb_fir_fft_framer
// Self-checking bench for fir_fft_framer. A reference model holds the
// buffered samples in a queue and tracks packet progress. A negedge process
// compares the DUT outputs against that model on every cycle. Directed
// literal checks pin down the rounding, saturation, framing, overflow and
// reset behaviour.
// -----------------------------------------------------------------------------
module tb_fir_fft_framer;
    localparam int IN_W      = 37;
    localparam int OUT_W     = 16;
    localparam int SHIFT     = 12;
    localparam int FRAME_LEN = 256;
    localparam int DEPTH     = 512;
    localparam int MAXV      = (1 << (OUT_W-1)) - 1;
    localparam int MINV      = -(1 << (OUT_W-1));

    logic             clk;
    logic             rst_n;
    logic [IN_W-1:0]  fir_data;
    logic             fir_valid;
    logic [OUT_W-1:0] src_data;
    logic             src_valid;
    logic             src_sop;
    logic             src_eop;
    logic             src_ready;
    logic             ovf;
    logic             sat;

    int checks = 0;
    int errors = 0;

    int m_q[$];
    bit m_in_pkt = 1'b0;
    int m_beat   = 0;
    bit m_pend_v = 1'b0;
    int m_pend   = 0;
    bit m_ovf    = 1'b0;
    bit m_sat    = 1'b0;
    bit chk_en   = 1'b0;
    int cyc      = 0;

    int acc_q[$];
    bit acc_sop[$];
    bit acc_eop[$];
    int acc_cyc[$];

    fir_fft_framer #(
        .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT),
        .FRAME_LEN(FRAME_LEN), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .fir_data(fir_data), .fir_valid(fir_valid),
        .src_data(src_data), .src_valid(src_valid), .src_sop(src_sop),
        .src_eop(src_eop), .src_ready(src_ready), .ovf(ovf), .sat(sat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int model_scale(input logic [IN_W-1:0] d, output bit s);
        longint v;
        longint r;
        v = longint'($signed(d));
        r = (v + (longint'(1) << (SHIFT-1))) >>> SHIFT;
        s = 1'b0;
        if (r > MAXV) begin
            r = MAXV;
            s = 1'b1;
        end else if (r < MINV) begin
            r = MINV;
            s = 1'b1;
        end
        return int'(r);
    endfunction

    // Reference model: sample buffer, drops and packet progress
    always @(posedge clk) begin : model_p
        int pre;
        bit acc;
        bit ss;
        cyc++;
        if (!rst_n) begin
            m_q.delete();
            m_in_pkt = 1'b0;
            m_beat   = 0;
            m_pend_v = 1'b0;
            m_ovf    = 1'b0;
            m_sat    = 1'b0;
        end else begin
            pre = m_q.size();
            acc = m_in_pkt && src_ready;
            if (acc) begin
                void'(m_q.pop_front());
                m_beat++;
                if (m_beat == FRAME_LEN) begin
                    m_in_pkt = 1'b0;
                    m_beat   = 0;
                end
            end else if (!m_in_pkt && pre >= FRAME_LEN) begin
                m_in_pkt = 1'b1;
                m_beat   = 0;
            end
            if (m_pend_v) begin
                if (pre == DEPTH && !acc) m_ovf = 1'b1;
                else m_q.push_back(m_pend);
            end
            m_pend_v = fir_valid;
            if (fir_valid) begin
                m_pend = model_scale(fir_data, ss);
                if (ss) m_sat = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model, plus recording of accepted beats
    always @(negedge clk) begin
        if (chk_en) begin
            check("valid", src_valid, m_in_pkt);
            check("ovf", ovf, m_ovf);
            check("sat", sat, m_sat);
            if (m_in_pkt) begin
                if (m_q.size() == 0) check("model_head_present", 0, 1);
                else check("data", $signed(src_data), m_q[0]);
                check("sop", src_sop, (m_beat == 0));
                check("eop", src_eop, (m_beat == FRAME_LEN-1));
            end else begin
                check("sop_idle", src_sop, 0);
                check("eop_idle", src_eop, 0);
            end
            if (rst_n && src_valid && src_ready) begin
                acc_q.push_back(int'($signed(src_data)));
                acc_sop.push_back(src_sop);
                acc_eop.push_back(src_eop);
                acc_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [IN_W-1:0] d);
        fir_valid = 1'b1;
        fir_data  = d;
        tick();
        fir_valid = 1'b0;
    endtask

    task automatic clear_acc();
        acc_q.delete();
        acc_sop.delete();
        acc_eop.delete();
        acc_cyc.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_acc(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (acc_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        check({name, "_beats_arrived"}, (acc_q.size() >= n), 1);
    endtask

    task automatic check_ramp(input string name, input int base, input int n);
        check({name, "_len"}, acc_q.size(), n);
        for (int i = 0; i < n && i < acc_q.size(); i++) begin
            check({name, "_val"}, acc_q[i], base + i);
            check({name, "_sop"}, acc_sop[i], ((i % FRAME_LEN) == 0));
            check({name, "_eop"}, acc_eop[i], ((i % FRAME_LEN) == FRAME_LEN-1));
        end
    endtask

    initial begin : stim
        int pv;
        bit ps;
        int bias;
        int k;
        rst_n     = 1'b0;
        fir_valid = 1'b0;
        fir_data  = '0;
        src_ready = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        tick();
        check("rst_valid", src_valid, 0);
        check("rst_sop", src_sop, 0);
        check("rst_eop", src_eop, 0);
        check("rst_data", src_data, 0);
        check("rst_ovf", ovf, 0);
        check("rst_sat", sat, 0);
        rst_n = 1'b1;
        tick();

        // Pin the reference scaling against hand-computed values
        pv = model_scale(37'h0000001800, ps); check("pin_1p5", pv, 2);
        pv = model_scale(37'h0000000800, ps); check("pin_0p5", pv, 1);
        pv = model_scale(37'h1FFFFFF800, ps); check("pin_m0p5", pv, 0);
        pv = model_scale(37'h0040000000, ps); check("pin_pos_sat", pv, 32767);
        pv = model_scale(37'h1FC0000000, ps); check("pin_neg_sat", pv, -32768);

        // Rounding and saturation, carried out through a full packet
        clear_acc();
        src_ready = 1'b1;
        send(37'h0000001800);
        send(37'h0000000800);
        send(37'h1FFFFFF800);
        send(37'h0040000000);
        send(37'h1FC0000000);
        for (int i = 0; i < FRAME_LEN-5; i++) begin
            send(IN_W'(longint'($urandom_range(0, 32'h00FF_FFFF)) - longint'(32'h0080_0000)));
        end
        wait_acc(FRAME_LEN, 600, "t12");
        if (acc_q.size() >= 5) begin
            check("t1_a", acc_q[0], 2);
            check("t1_b", acc_q[1], 1);
            check("t1_c", acc_q[2], 0);
            check("t2_pos", acc_q[3], 32767);
            check("t2_neg", acc_q[4], -32768);
        end
        check("t2_sat", sat, 1);
        check("t2_ovf", ovf, 0);
        tick();
        do_reset();
        check("rst2_valid", src_valid, 0);
        check("rst2_sat", sat, 0);

        // Ramp with ready held high: one continuous packet
        clear_acc();
        for (int i = 0; i < FRAME_LEN; i++) send(IN_W'(i) << SHIFT);
        wait_acc(FRAME_LEN, 400, "t3");
        check_ramp("t3", 0, FRAME_LEN);
        if (acc_cyc.size() == FRAME_LEN)
            check("t3_continuous", acc_cyc[FRAME_LEN-1] - acc_cyc[0], FRAME_LEN-1);

        // Ramp with ready toggling every cycle
        clear_acc();
        for (int i = 0; i < FRAME_LEN; i++) send(IN_W'(i) << SHIFT);
        k = 0;
        while (acc_q.size() < FRAME_LEN && k < 1200) begin
            src_ready = k[0];
            tick();
            k++;
        end
        src_ready = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check_ramp("t4", 0, FRAME_LEN);

        // Overflow: 600 samples arrive while the sink is stalled
        do_reset();
        clear_acc();
        src_ready = 1'b0;
        for (int i = 0; i < 600; i++) send(IN_W'(i) << SHIFT);
        for (int i = 0; i < 5; i++) tick();
        check("t5_ovf", ovf, 1);
        src_ready = 1'b1;
        wait_acc(2*FRAME_LEN, 1200, "t5");
        for (int i = 0; i < 20; i++) tick();
        check_ramp("t5", 0, 2*FRAME_LEN);

        // Reset in the middle of a packet
        do_reset();
        clear_acc();
        src_ready = 1'b1;
        for (int i = 0; i < FRAME_LEN; i++) send(IN_W'(1000 + i) << SHIFT);
        wait_acc(100, 400, "t6_pre");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t6_valid", src_valid, 0);
        check("t6_ovf", ovf, 0);
        check("t6_sat", sat, 0);
        clear_acc();
        for (int i = 0; i < 10; i++) tick();
        check("t6_no_beats", acc_q.size(), 0);
        for (int i = 0; i < FRAME_LEN; i++) send(IN_W'(2000 + i) << SHIFT);
        wait_acc(FRAME_LEN, 600, "t6");
        check_ramp("t6", 2000, FRAME_LEN);

        // Randomized traffic, checked cycle by cycle against the model
        do_reset();
        clear_acc();
        bias = 50;
        for (int i = 0; i < 4000; i++) begin
            if ((i % 256) == 0) bias = $urandom_range(0, 100);
            fir_valid = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 9) == 0)
                fir_data = IN_W'({$urandom(), $urandom()});
            else
                fir_data = IN_W'(longint'($urandom_range(0, 32'h0FFF_FFFF)) - longint'(32'h0800_0000));
            src_ready = ($urandom_range(0, 99) < bias);
            tick();
        end
        fir_valid = 1'b0;
        src_ready = 1'b1;
        for (int i = 0; i < 700; i++) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
